fios_mm_stream_ctrl: RTL and testbench

//   Streaming front-end for the FIOS Montgomery multiplier, parametrised in word width, operand length and PE count.

---
 rtl/fios_mm_stream_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_fios_mm_stream_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fios_mm_stream_ctrl.sv
// Operand buffering / core sequencing / result FIFO front-end for the FIOS Montgomery core.
// Last operand beat -> core_start_o in 2 cycles; holds start until the FIFO can absorb a full result.

module fios_mm_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          drop_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          full, wr_en, rd_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rd_en   = pop_i && !empty_o;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign wr_en   = push_i && (!full || rd_en);
  assign drop_o  = push_i && full && !rd_en;

  assign pop_data_o = mem_q[rptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clock_i) begin
    if (wr_en) mem_q[wptr_q] <= push_data_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (rd_en) rptr_q <= rptr_q + AW'(1);
      if (wr_en && !rd_en)      count_q <= count_q + CW'(1);
      else if (!wr_en && rd_en) count_q <= count_q - CW'(1);
    end
  end
endmodule

module fios_mm_stream_ctrl #(
  parameter int W         = 17,
  parameter int S         = 8,
  parameter int PE_NB     = 8,
  parameter int OUT_DEPTH = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               op_valid_i,
  output logic               op_ready_o,
  input  logic [W-1:0]       op_a_i,
  input  logic [W-1:0]       op_b_i,
  input  logic [W-1:0]       op_p_i,
  output logic               core_start_o,
  output logic [PE_NB*W-1:0] core_a_o,
  input  logic               core_a_shift_i,
  output logic [W-1:0]       core_b_o,
  input  logic               core_b_fetch_i,
  output logic [W-1:0]       core_p_o,
  input  logic               core_p_fetch_i,
  input  logic               core_res_push_i,
  input  logic [W-1:0]       core_res_i,
  input  logic               core_done_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [W-1:0]       res_data_o,
  output logic               res_last_o,
  output logic               busy_o,
  output logic               err_o
);
  localparam int SW = $clog2(S);
  localparam int G  = (S + PE_NB - 1) / PE_NB;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [CW-1:0] MAX_FILL = CW'(OUT_DEPTH - S);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_SPACE, START, RUN} state_e;
  state_e state_q, state_d;

  logic [W-1:0]  a_buf_q [S];
  logic [W-1:0]  b_buf_q [S];
  logic [W-1:0]  p_buf_q [S];
  logic [W-1:0]  a_pad   [G*PE_NB];
  logic [SW-1:0] beat_q, b_ptr_q, p_ptr_q, out_cnt_q;
  logic [GW-1:0] g_q;
  logic          err_q;

  logic              ready_int, accept, pop, fifo_empty, fifo_drop;
  logic [CW-1:0]     fifo_count;
  logic [W-1:0]      fifo_head, b_word, p_word;
  logic [PE_NB*W-1:0] a_group;

  assign ready_int = (state_q == IDLE) || (state_q == LOAD);
  assign accept    = op_valid_i && ready_int;
  assign pop       = !fifo_empty && res_ready_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (op_valid_i) state_d = LOAD;
      LOAD:       if (op_valid_i && beat_q == SW'(S - 1)) state_d = WAIT_SPACE;
      WAIT_SPACE: if (fifo_count <= MAX_FILL) state_d = START;
      START:      state_d = RUN;
      RUN:        if (core_done_i) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Every output is forced low while reset is asserted, before the registers clear.
  always_comb begin
    op_ready_o   = !reset_i && ready_int;
    core_start_o = !reset_i && (state_q == START);
    busy_o       = !reset_i && (state_q != IDLE);
    err_o        = !reset_i && err_q;
    res_valid_o  = !reset_i && !fifo_empty;
    res_data_o   = reset_i ? '0 : fifo_head;
    res_last_o   = !reset_i && !fifo_empty && (out_cnt_q == SW'(S - 1));
    core_a_o     = reset_i ? '0 : a_group;
    core_b_o     = reset_i ? '0 : b_word;
    core_p_o     = reset_i ? '0 : p_word;
  end

  always_ff @(posedge clock_i) begin
    for (int i = 0; i < S; i++) begin
      if (accept && beat_q == SW'(i)) begin
        a_buf_q[i] <= op_a_i;
        b_buf_q[i] <= op_b_i;
        p_buf_q[i] <= op_p_i;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      beat_q    <= '0;
      g_q       <= '0;
      b_ptr_q   <= '0;
      p_ptr_q   <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) beat_q <= (beat_q == SW'(S - 1)) ? '0 : beat_q + SW'(1);
      if (state_q == START) begin
        g_q     <= '0;
        b_ptr_q <= '0;
        p_ptr_q <= '0;
      end else if (state_q == RUN) begin
        if (core_a_shift_i) g_q <= (g_q == GW'(G - 1)) ? '0 : g_q + GW'(1);
        if (core_b_fetch_i) b_ptr_q <= (b_ptr_q == SW'(S - 1)) ? '0 : b_ptr_q + SW'(1);
        if (core_p_fetch_i) p_ptr_q <= (p_ptr_q == SW'(S - 1)) ? '0 : p_ptr_q + SW'(1);
      end
      if (pop) out_cnt_q <= (out_cnt_q == SW'(S - 1)) ? '0 : out_cnt_q + SW'(1);
      if (fifo_drop) err_q <= 1'b1;
    end
  end

  // The last a group runs past the operand; those lanes read as zero.
  for (genvar i = 0; i < G*PE_NB; i++) begin : g_apad
    if (i < S) begin : g_real
      assign a_pad[i] = a_buf_q[i];
    end else begin : g_zero
      assign a_pad[i] = '0;
    end
  end

  always_comb begin
    a_group = '0;
    for (int g = 0; g < G; g++) begin
      if (g_q == GW'(g)) begin
        for (int k = 0; k < PE_NB; k++) a_group[k*W +: W] = a_pad[g*PE_NB + k];
      end
    end
  end

  always_comb begin
    b_word = '0;
    p_word = '0;
    for (int i = 0; i < S; i++) begin
      if (b_ptr_q == SW'(i)) b_word = b_buf_q[i];
      if (p_ptr_q == SW'(i)) p_word = p_buf_q[i];
    end
  end

  fios_mm_fifo #(.W(W), .DEPTH(OUT_DEPTH)) u_res_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (core_res_push_i),
    .push_data_i (core_res_i),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );
endmodule

// File: tb/tb_fios_mm_stream_ctrl.sv
// Directed bench for fios_mm_stream_ctrl (S=8, PE_NB=3, OUT_DEPTH=16) with a result scoreboard.
module tb_fios_mm_stream_ctrl;
  localparam int W = 17, S = 8, PE = 3, OD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, op_valid, op_ready, core_start, a_shift, b_fetch, p_fetch;
  logic            res_push, core_done, res_valid, res_ready, res_last, busy, err;
  logic [W-1:0]    op_a, op_b, op_p, core_b, core_p, core_res, res_data;
  logic [PE*W-1:0] core_a;

  fios_mm_stream_ctrl #(.W(W), .S(S), .PE_NB(PE), .OUT_DEPTH(OD)) dut (
    .clock_i(clk), .reset_i(rst),
    .op_valid_i(op_valid), .op_ready_o(op_ready),
    .op_a_i(op_a), .op_b_i(op_b), .op_p_i(op_p),
    .core_start_o(core_start), .core_a_o(core_a), .core_a_shift_i(a_shift),
    .core_b_o(core_b), .core_b_fetch_i(b_fetch),
    .core_p_o(core_p), .core_p_fetch_i(p_fetch),
    .core_res_push_i(res_push), .core_res_i(core_res), .core_done_i(core_done),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_last_o(res_last), .busy_o(busy), .err_o(err)
  );

  int checks = 0;
  int passes = 0;
  int popcnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] a_v[S], b_v[S], p_v[S];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PE*W-1:0] grp(input int g);
    logic [PE*W-1:0] r;
    r = '0;
    for (int k = 0; k < PE; k++) begin
      int idx;
      idx = g*PE + k;
      if (idx < S) r[k*W +: W] = a_v[idx];
    end
    return r;
  endfunction

  task automatic load_op();
    for (int i = 0; i < S; i++) begin
      op_valid = 1'b1;
      op_a = a_v[i];
      op_b = b_v[i];
      op_p = p_v[i];
      @(negedge clk);
      chk("op_ready_load", op_ready, 1);
      edge_();
    end
    op_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (core_start) seen = 1'b1;
      edge_();
    end
    chk("start_seen", seen, 1);
  endtask

  task automatic push_results(input int base, input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      res_push  = 1'b1;
      core_res  = W'(base + i);
      core_done = with_done && (i == n - 1);
      exp_q.push_back(W'(base + i));
      edge_();
    end
    res_push  = 1'b0;
    core_done = 1'b0;
  endtask

  // Scoreboard consumer: every handshake pops one expected word.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) popcnt = 0;
    else if (res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e);
        chk("res_last", res_last, popcnt == S - 1);
      end
      popcnt = (popcnt + 1) % S;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; op_valid = 0; a_shift = 0; b_fetch = 0; p_fetch = 0;
    res_push = 0; core_done = 0; res_ready = 0;
    op_a = '0; op_b = '0; op_p = '0; core_res = '0;
    for (int i = 0; i < S; i++) begin
      a_v[i] = W'(i + 1);
      b_v[i] = W'(i + 9);
      p_v[i] = W'(i + 17);
    end

    // Reset state
    @(negedge clk);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_core_a", core_a, 0);
    edge_(); edge_();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_op_ready", op_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_err", err, 0);
    edge_();

    // Operation 1: start latency, a groups, b/p pointers, results
    res_ready = 1'b1;
    load_op();
    @(negedge clk);
    chk("lat1_start", core_start, 0);
    chk("lat1_busy", busy, 1);
    chk("lat1_op_ready", op_ready, 0);
    edge_();
    @(negedge clk);
    chk("lat2_start", core_start, 1);
    edge_();
    @(negedge clk);
    chk("run_start_low", core_start, 0);
    chk("a_group_0", core_a, grp(0));
    for (int s = 1; s <= 4; s++) begin
      a_shift = 1'b1;
      edge_();
      a_shift = 1'b0;
      @(negedge clk);
      chk("a_group_shift", core_a, grp(s % 3));
    end
    edge_();
    b_fetch = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("b_seq", core_b, b_v[i % S]);
      chk("p_hold", core_p, p_v[0]);
      edge_();
    end
    b_fetch = 1'b0;
    @(negedge clk);
    chk("b_after_wrap", core_b, b_v[2]);
    edge_();
    p_fetch = 1'b1;
    edge_();
    p_fetch = 1'b0;
    @(negedge clk);
    chk("p_fetch", core_p, p_v[1]);
    chk("b_indep", core_b, b_v[2]);
    chk("res_valid_empty", res_valid, 0);
    edge_();
    push_results(100, S, 1'b1);
    @(negedge clk);
    chk("done_busy", busy, 0);
    chk("done_op_ready", op_ready, 1);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) edge_();
    chk("drain1", exp_q.size(), 0);

    // Fill the FIFO with two results, then error behaviour on full
    res_ready = 1'b0;
    load_op();
    wait_start(10);
    push_results(200, S, 1'b1);
    load_op();
    wait_start(10);
    push_results(300, S, 1'b0);
    @(negedge clk);
    chk("full_err0", err, 0);
    edge_();
    res_ready = 1'b1;
    res_push  = 1'b1;
    core_res  = W'(400);
    exp_q.push_back(W'(400));
    edge_();
    res_ready = 1'b0;
    res_push  = 1'b0;
    @(negedge clk);
    chk("pushpop_full_err", err, 0);
    edge_();
    res_push  = 1'b1;
    core_res  = W'(500);
    core_done = 1'b1;
    edge_();
    res_push  = 1'b0;
    core_done = 1'b0;
    @(negedge clk);
    chk("drop_err", err, 1);
    chk("drop_idle", busy, 0);
    edge_();

    // Third operation must wait for space
    load_op();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("stall_start", core_start, 0);
      chk("stall_busy", busy, 1);
      chk("stall_op_ready", op_ready, 0);
      edge_();
    end
    chk("err_sticky", err, 1);
    res_ready = 1'b1;
    repeat (S) edge_();
    res_ready = 1'b0;
    wait_start(10);
    chk("queue_left", exp_q.size(), 8);

    // Reset in RUN
    rst = 1'b1;
    @(negedge clk);
    chk("rstrun_busy", busy, 0);
    chk("rstrun_op_ready", op_ready, 0);
    chk("rstrun_res_valid", res_valid, 0);
    chk("rstrun_err", err, 0);
    edge_();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("postrst_busy", busy, 0);
    chk("postrst_res_valid", res_valid, 0);
    chk("postrst_op_ready", op_ready, 1);
    chk("postrst_err", err, 0);
    edge_();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
